// File: rtl/dev_bridge_intc.sv
// System bridge between the CPU data port and NDEV memory-mapped devices, plus the interrupt
// front-end with a shared hardware ack FSM. Define BRIDGE_IRQ_SYNC_EN to add a 2-flop ext_irq synchronizer.
module dev_bridge_intc #(
    parameter int          NDEV        = 2,
    parameter int          NEXT        = 1,
    parameter logic [31:0] DEV_BASE    = 32'h0000_7F00,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pr_addr,
    input  logic [31:0]          pr_wd,
    input  logic                 pr_we,
    output logic [31:0]          pr_rd,
    output logic                 pr_hit,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wd,
    output logic [NDEV-1:0]      dev_we,
    input  logic [32*NDEV-1:0]   dev_rd,
    input  logic [NDEV-1:0]      dev_irq,
    input  logic [NEXT-1:0]      ext_irq,
    output logic [NEXT-1:0]      ext_ack,
    input  logic                 int_taken,
    output logic [5:0]           hw_int
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAITDROP} state_t;

    state_t            state_reg, state_next;
    logic [NEXT-1:0]   tgt_reg, tgt_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [NEXT-1:0]   err_reg, err_next;
    logic [NEXT-1:0]   ext_s;
    logic [NEXT-1:0]   req_mask;
    logic [NEXT-1:0]   err_clr;
    logic [31:0]       dev_off;
    logic [NDEV-1:0]   dev_hit;
    logic              ack_hit;
    logic              ack_wr;
    logic              stat_wr;
    logic              busy;
    logic [31:0]       ack_val;
    logic [31:0]       stat_val;

`ifdef BRIDGE_IRQ_SYNC_EN
    logic [NEXT-1:0] sync1_reg, sync2_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= ext_irq;
            sync2_reg <= sync1_reg;
        end
    end

    assign ext_s = sync2_reg;
`else
    assign ext_s = ext_irq;
`endif

    // Windows are 16-byte slots above DEV_BASE; the slot just past the devices holds ACK/STAT.
    assign dev_off = pr_addr - DEV_BASE;

    genvar gi;
    generate
        for (gi = 0; gi < NDEV; gi++) begin : g_dec
            assign dev_hit[gi] = (dev_off[31:4] == 28'(gi));
        end
    endgenerate

    assign ack_hit  = (dev_off[31:4] == 28'(NDEV));
    assign ack_wr   = pr_we & ack_hit & (dev_off[3:0] == 4'h0);
    assign stat_wr  = pr_we & ack_hit & (dev_off[3:0] == 4'h4);
    assign pr_hit   = (|dev_hit) | ack_hit;
    assign dev_we   = pr_we ? dev_hit : '0;
    assign dev_addr = pr_addr;
    assign dev_wd   = pr_wd;
    assign busy     = (state_reg != S_IDLE);
    assign err_clr  = stat_wr ? pr_wd[NEXT:1] : '0;

    always_comb begin
        ack_val             = '0;
        ack_val[NEXT-1:0]   = ext_s;
        stat_val            = '0;
        stat_val[NEXT:1]    = err_reg;
        stat_val[0]         = busy;
        pr_rd               = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (dev_hit[i]) pr_rd = dev_rd[32*i +: 32];
        end
        if (ack_hit) begin
            if (dev_off[3:0] == 4'h0)      pr_rd = ack_val;
            else if (dev_off[3:0] == 4'h4) pr_rd = stat_val;
        end
    end

    // External bits are forced low while reset is held, even without the synchronizer.
    always_comb begin
        hw_int               = '0;
        hw_int[NDEV-1:0]     = dev_irq;
        hw_int[NDEV +: NEXT] = reset ? ext_s : '0;
    end

    // int_taken picks the lowest asserted line (x & -x); a same-cycle ACK write is OR-merged.
    assign req_mask = (int_taken ? (ext_s & (-ext_s)) : '0) | (ack_wr ? pr_wd[NEXT-1:0] : '0);

    always_comb begin
        state_next = state_reg;
        tgt_next   = tgt_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg & ~err_clr;
        ext_ack    = '0;
        case (state_reg)
            S_IDLE: begin
                if (|req_mask) begin
                    tgt_next   = req_mask;
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                ext_ack    = tgt_reg;
                cnt_next   = 8'(ACK_TIMEOUT);
                state_next = S_WAITDROP;
            end
            S_WAITDROP: begin
                if ((ext_s & tgt_reg) == '0) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                    if (cnt_reg == 8'd1) begin
                        err_next   = err_next | (tgt_reg & ext_s);
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            tgt_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

endmodule
